pattern_scan_ctrl: RTL and testbench

Controller that scans a parallel data word for occurrences of the serial pattern 10010. It loads a WIDTH-bit word on a start request and feeds it MSB-first, one bit per clock, through an embedded 6-state Moore 10010 detector. It counts overlapping matches and reports the total with a busy/done handshake. The block sits between a word-producing host and the team's serial sequence-detector datapath, sequencing and resetting the detector on a per-word basis.

---
 rtl/pattern_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: loads a word on start and feeds it MSB-first into an
// embedded Moore detector for the serial pattern 10010. It counts overlapping
// matches (saturating) and reports the total with a busy/done handshake.
module pattern_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [CNT_W-1:0] count
);

  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } ctrl_t;

  // Detector states name the suffix of 10010 matched so far.
  typedef enum logic [2:0] {
    D_A,  // nothing
    D_B,  // "1"
    D_C,  // "10"
    D_D,  // "100"
    D_E,  // "1001"
    D_F   // "10010" (match)
  } det_t;

  ctrl_t            state_reg, state_next;
  det_t             det_reg, det_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             w;
  logic             count_en;

  // One detector step; F on 0 falls back to D so overlapping matches count.
  function automatic det_t det_step(input det_t cur, input logic j);
    det_t nxt;
    case (cur)
      D_A:     nxt = j ? D_B : D_A;
      D_B:     nxt = j ? D_B : D_C;
      D_C:     nxt = j ? D_B : D_D;
      D_D:     nxt = j ? D_E : D_A;
      D_E:     nxt = j ? D_B : D_F;
      D_F:     nxt = j ? D_B : D_D;
      default: nxt = D_A;
    endcase
    return nxt;
  endfunction

  // Moore match flag; only counted while a scan is running.
  assign w        = (det_reg == D_F);
  assign count_en = w && ((state_reg == S_SHIFT) || (state_reg == S_DRAIN));

  // State register: control FSM, detector and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      det_reg   <= D_A;
      shreg_reg <= '0;
      idx_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      det_reg   <= det_next;
      shreg_reg <= shreg_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic for the FSM, detector, shifter, bit index and counter.
  always_comb begin
    state_next = state_reg;
    det_next   = det_reg;
    shreg_next = shreg_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    case (state_reg)
      S_IDLE: begin
        // A start here wins even if abort is high in the same cycle.
        if (start) begin
          shreg_next = din;
          count_next = '0;
          idx_next   = '0;
          det_next   = D_A;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        det_next   = det_step(det_reg, shreg_reg[WIDTH-1]);
        shreg_next = shreg_reg << 1;
        idx_next   = idx_reg + IDX_W'(1);
        if (abort) begin
          state_next = S_IDLE;
        end else if (idx_reg == LAST_IDX) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // No bit presented: the detector holds so a match on the last bit
        // is still seen and counted here.
        state_next = abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (count_en && (count_reg != CNT_MAX)) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  // Outputs: decoded from registered state, forced low while reset is held.
  always_comb begin
    busy  = !rst && ((state_reg == S_SHIFT) || (state_reg == S_DRAIN));
    done  = !rst && (state_reg == S_DONE);
    match = !rst && count_en;
    count = count_reg;
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: randomized scans (normal, aborted, reset
// mid-scan) with a queue of expected outcomes computed by a sliding-window
// search for 10010, checked by an independent monitor on two instances
// (CNT_W=5 and CNT_W=2).
module tb_pattern_scan_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] din = '0;
  logic         busy, done, match;
  logic [4:0]   count;
  logic         busy2, done2, match2;
  logic [1:0]   count2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          e;         // cycle (relative to start cycle) where busy drops
    bit          done_exp;
    logic [31:0] mask;      // cycles with an expected match pulse
    int          c5;
    int          c2;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .din(din),
    .busy(busy), .done(done), .match(match), .count(count)
  );

  pattern_scan_ctrl #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .din(din),
    .busy(busy2), .done(done2), .match(match2), .count(count2)
  );

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: run to completion, 1: abort in cycle 'at', 2: reset in cycle 'at'
  task automatic scan(input logic [W-1:0] d, input int mode, input int at, input bit noise);
    int   b[1:W];
    int   e;
    int   n;
    exp_t x;
    for (int i = 1; i <= W; i++) b[i] = int'(d[W-i]);
    e = (mode == 0) ? W + 2 : ((mode == 1) ? at + 1 : at);
    n = 0;
    x.mask = '0;
    for (int k = 5; k <= W; k++) begin
      if (b[k-4] == 1 && b[k-3] == 0 && b[k-2] == 0 && b[k-1] == 1 && b[k] == 0) begin
        if (k + 1 < e) begin
          x.mask[k+1] = 1'b1;
          n++;
        end
      end
    end
    x.e        = e;
    x.done_exp = (mode == 0);
    x.c5       = (n > 31) ? 31 : n;
    x.c2       = (n > 3) ? 3 : n;
    sbq.push_back(x);
    $display("scan din=%h mode=%0d at=%0d expect end=%0d count=%0d count2=%0d",
             d, mode, at, e, x.c5, x.c2);
    din   = d;
    start = 1'b1;
    abort = 1'($urandom_range(0, 1));
    rst   = 1'b0;
    tick();
    for (int off = 1; off <= e; off++) begin
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      din   = W'($urandom);
      if (noise && off < e && $urandom_range(0, 3) == 0) start = 1'b1;
      if (mode == 1 && off == at) abort = 1'b1;
      if (mode == 2 && off == at) rst = 1'b1;
      if (mode == 0 && off == e) abort = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  // Monitor: tracks each busy window and compares it against the queue.
  initial begin
    bit          in_scan = 1'b0;
    bit          rst_d = 1'b0;
    int          off = 0;
    int          hold = 0;
    int          hold2 = 0;
    logic [31:0] m5, m2, b2;
    exp_t        x;
    m5 = '0; m2 = '0; b2 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_outputs", {busy, done, match, busy2, done2, match2}, 0);
      end else if (rst_d) begin
        chk("post_rst_outputs", {busy, done, match, count, busy2, done2, match2, count2}, 0);
        hold  = 0;
        hold2 = 0;
      end
      if (!in_scan && busy) begin
        in_scan = 1'b1;
        off = 1;
        m5 = '0; m2 = '0; b2 = '0;
      end else if (in_scan) begin
        off++;
      end
      if (in_scan) begin
        if (off <= 31) begin
          if (match)  m5[off] = 1'b1;
          if (match2) m2[off] = 1'b1;
          if (busy2)  b2[off] = 1'b1;
        end
        if (off > W + 4) begin
          chk("busy_timeout", off, W + 2);
          in_scan = 1'b0;
        end
      end
      if (in_scan && !busy) begin
        in_scan = 1'b0;
        if (sbq.size() == 0) begin
          chk("unexpected_scan_end", 1, 0);
        end else begin
          x = sbq.pop_front();
          chk("end_cycle", off, x.e);
          chk("done", done, x.done_exp);
          chk("done2", done2, x.done_exp);
          chk("match_mask", m5, x.mask);
          chk("match_mask2", m2, x.mask);
          chk("busy2_mask", b2, (32'd1 << x.e) - 32'd2);
          chk("count", count, x.c5);
          chk("count2", count2, x.c2);
          hold  = x.c5;
          hold2 = x.c2;
        end
      end else if (!in_scan && !rst && !rst_d) begin
        chk("idle_quiet", {done, match, busy2, done2, match2}, 0);
        chk("idle_count", count, hold);
        chk("idle_count2", count2, hold2);
      end
      rst_d = rst;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] p;
    logic [W-1:0] d;
    int           r, mode, at;
    p = 16'h9249;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    scan(16'h9249, 0, 0, 1'b0);
    scan(16'h0000, 0, 0, 1'b0);
    scan(16'h0012, 0, 0, 1'b0);
    scan(16'h9249, 1, 10, 1'b0);
    scan(16'h0012, 0, 0, 1'b0);
    scan(16'h9249, 2, 8, 1'b1);
    scan(16'h0012, 1, W + 1, 1'b0);
    scan(16'h9249, 0, 0, 1'b1);

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, W - 1);
      case ($urandom_range(0, 2))
        0:       d = W'($urandom);
        1:       d = (p << r) | (p >> (W - r));
        default: d = p ^ (W'(1) << r);
      endcase
      mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      at   = $urandom_range(1, W + 1);
      scan(d, mode, at, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        abort = 1'($urandom_range(0, 1));
        tick();
      end
      abort = 1'b0;
    end

    repeat (3) tick();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
